// File: rtl/ring_buff_arb.sv
// Round-robin write arbiter for a shared ring buffer: grants one producer a bounded
// burst, throttles grants by occupancy hysteresis, and paces reads from consumer readiness.
module ring_buff_arb #(
    parameter int  NUM_REQ     = 4,
    parameter int  WIDTH_REQ   = $clog2(NUM_REQ),
    parameter int  DEPTH_BUFF  = 16,
    parameter int  WIDTH_DEPTH = $clog2(DEPTH_BUFF),
    parameter int  MAX_BURST   = 4,
    parameter int  THRESH_HI   = DEPTH_BUFF - 2,
    parameter int  THRESH_LO   = DEPTH_BUFF / 2,
    parameter type TYPE_FWRD   = logic [7:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     I_Req,
    input  logic [NUM_REQ-1:0]     I_Last,
    input  TYPE_FWRD               I_FTk [NUM_REQ],
    output logic [NUM_REQ-1:0]     O_Ack,
    output logic                   O_Busy,
    output logic [WIDTH_REQ-1:0]   O_GrantID,
    output logic                   O_We,
    output TYPE_FWRD               O_FTk,
    input  logic                   I_Full,
    input  logic [WIDTH_DEPTH:0]   I_Num,
    input  logic                   I_Empty,
    input  logic                   I_Rdy,
    output logic                   O_Re
);

    localparam int WIDTH_CNT = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH_REQ-1:0]   grant_q, grant_d;
    logic [WIDTH_REQ-1:0]   ptr_q, ptr_d;
    logic [WIDTH_CNT-1:0]   cnt_q, cnt_d;
    logic                   rd_en_q, rd_en_d;

    logic                   num_hi;
    logic                   num_lo;
    logic                   we;
    logic                   win_vld;
    logic [WIDTH_REQ-1:0]   win_idx;
    logic [WIDTH_REQ-1:0]   rot_idx [NUM_REQ];

    assign num_hi = (I_Num >= (WIDTH_DEPTH+1)'(THRESH_HI));
    assign num_lo = (I_Num <  (WIDTH_DEPTH+1)'(THRESH_LO));

    // rot_idx[k] is the requester k positions after the pointer, wrapping at NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [WIDTH_REQ:0] sum;
            assign sum = {1'b0, ptr_q} + (WIDTH_REQ+1)'(gi);
            assign rot_idx[gi] = (sum >= (WIDTH_REQ+1)'(NUM_REQ))
                               ? WIDTH_REQ'(sum - (WIDTH_REQ+1)'(NUM_REQ))
                               : sum[WIDTH_REQ-1:0];
        end
    endgenerate

    // Scan from the far end so the requester closest to the pointer is assigned last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (I_Req[rot_idx[i]]) begin
                win_vld = 1'b1;
                win_idx = rot_idx[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !num_hi) begin
                    grant_d = win_idx;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                we = I_Req[grant_q] & ~I_Full;
                // Release takes precedence over a simultaneous occupancy stall.
                if (!I_Req[grant_q] ||
                    (we && (I_Last[grant_q] || cnt_q == WIDTH_CNT'(MAX_BURST - 1)))) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (grant_q == WIDTH_REQ'(NUM_REQ - 1)) ? '0
                                                                   : grant_q + WIDTH_REQ'(1);
                end else begin
                    if (we) begin
                        cnt_d = cnt_q + WIDTH_CNT'(1);
                    end
                    if (num_hi) begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (num_lo) begin
                    state_d = ST_BURST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read side stays quiet until the first edge after reset release.
    assign rd_en_d = 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign O_Ack[gi] = we && (grant_q == WIDTH_REQ'(gi));
        end
    endgenerate

    assign O_Busy    = (state_q != ST_IDLE);
    assign O_GrantID = O_Busy ? grant_q : '0;
    assign O_We      = we;
    assign O_FTk     = we ? I_FTk[grant_q] : '0;
    assign O_Re      = I_Rdy & ~I_Empty & rd_en_q;

endmodule

// File: doc/ring_buff_arb.md
Name: ring_buff_arb

Overview:
Round-robin write arbiter and flow scheduler placed in front of one shared RingBuff instance. It grants one of NUM_REQ producers exclusive write access for a bounded burst and steers that producer's token into the buffer. Write grants are throttled by a high/low occupancy hysteresis on the buffer's entry count. Read enables are paced from consumer readiness and buffer emptiness.

Parameters:
NUM_REQ, 4, number of producer ports.
WIDTH_REQ, $clog2(NUM_REQ), width of the grant index.
DEPTH_BUFF, 16, depth of the attached RingBuff.
WIDTH_DEPTH, $clog2(DEPTH_BUFF), width of the buffer's entry-count port minus 1.
MAX_BURST, 4, maximum number of words accepted per grant (must be ≥1).
THRESH_HI, DEPTH_BUFF-2, occupancy at or above which new writes stall.
THRESH_LO, DEPTH_BUFF/2, occupancy below which a stall is released.
TYPE_FWRD, FTk_t, token type.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
I_Req  in  NUM_REQ  per-producer write request.
I_Last  in  NUM_REQ  per-producer flag marking the final word of a burst.
I_FTk  in  NUM_REQ x TYPE_FWRD  per-producer token.
O_Ack  out  NUM_REQ  one-hot; the word on that port is written this cycle.
O_Busy  out  1  a grant is held (state BURST or STALL).
O_GrantID  out  WIDTH_REQ  index of the granted producer; valid only while O_Busy.
O_We  out  1  write enable to the buffer.
O_FTk  out  TYPE_FWRD  token to the buffer; '0 when O_We=0.
I_Full  in  1  buffer full flag.
I_Num  in  WIDTH_DEPTH+1  buffer entry count (registered by the buffer controller).
I_Empty  in  1  buffer empty flag.
I_Rdy  in  1  downstream consumer ready.
O_Re  out  1  read enable to the buffer.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; grant register, round-robin pointer and burst counter all 0.
  - All outputs 0 while reset is asserted and in the first cycle after release.
- States: IDLE, BURST, STALL.
  - IDLE: if any I_Req, register the winner as the first requester at or after the pointer (wrapping), then go to BURST. Grant latency is 1 cycle. No word is accepted in IDLE.
  - BURST: O_We = I_Req[g] & ~I_Full. O_Ack[g]=O_We. O_FTk = I_FTk[g]. The burst counter increments on each O_We.
  - Release BURST→IDLE on the edge where:
    - an accepted word has I_Last[g]=1, or
    - the counter reaches MAX_BURST, or
    - I_Req[g]=0 (no word is acked in that cycle).
  - On release: pointer = (g+1) mod NUM_REQ and the counter is cleared. A release costs one bubble cycle before the next grant.
  - BURST→STALL when the sampled I_Num ≥ THRESH_HI. In STALL: O_We=0, all O_Ack=0, grant and counter are held.
  - STALL→BURST when I_Num < THRESH_LO.
  - If I_Num ≥ THRESH_HI and a release condition occur on the same edge, release wins and the next state is IDLE.
- IDLE does not grant while I_Num ≥ THRESH_HI. The hysteresis is rechecked at the next grant.
- I_Full is an unconditional guard: O_We is never asserted with I_Full=1, regardless of state. This covers the one-cycle lag of I_Num.
- Read side is combinational and independent of arbitration: O_Re = I_Rdy & ~I_Empty. Simultaneous read and write are legal.
- Burst counter width is $clog2(MAX_BURST+1) and it never wraps.
- Reset mid-burst drops the grant immediately. Words already written stay in the buffer; the buffer is reset separately.
- Pointer wrap: NUM_REQ-1 → 0.

Test Plan:
1. Single burst with Last: only I_Req[2]=1, 3 words (0xA,0xB,0xC), I_Last on the third; buffer empty. Required: O_GrantID=2 one cycle after the request; O_We and O_Ack[2] high for 3 consecutive cycles with O_FTk=A,B,C; IDLE on the next cycle; pointer=3.
2. Round-robin fairness: all 4 requesters hold I_Req with I_Last on every word. Required: grants in order 0,1,2,3,0; exactly one word each; one bubble between grants.
3. MAX_BURST truncation: requester 1 streams 10 words with no I_Last. Required: release after 4 acks; requester 1 is re-granted only after every other active requester has been served.
4. Stall hysteresis: drive I_Num=14 mid-burst. Required: O_We=0 and state STALL. Drive I_Num=9: still stalled. Drive I_Num=7: BURST resumes with the same GrantID and counter.
5. Full guard and read pacing: I_Full=1 while I_Num=13 (lag case). Required: O_We=0. With I_Rdy=1 and I_Empty=0: O_Re=1 in the same cycle. With I_Empty=1: O_Re=0.
6. Asynchronous reset: assert reset between clock edges in the middle of a burst. Required: O_Busy, O_Ack and O_We fall without waiting for a clock edge; after release, the state is IDLE and the pointer is 0.
